// File: rtl/base_arb_pkg.sv
// Shared types and the rotate-priority pick for the round-robin arbiter.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable; consumers handle valid/ready.
package base_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Widest arbiter the pick helper supports; callers pass their real width.
  localparam int ARB_MAX_WAYS = 32;

  // Rotate-priority pick over the low n bits of req.
  // Returns the index of the first request strictly after the one-hot ptr,
  // wrapping around, or -1 when nothing is requested.
  // The request vector is laid out twice so the search window starting just
  // after ptr never has to wrap explicitly.
  function automatic int rr_pick(input logic [ARB_MAX_WAYS-1:0] req,
                                 input logic [ARB_MAX_WAYS-1:0] ptr,
                                 input int n);
    logic [2*ARB_MAX_WAYS-1:0] dbl;
    int base;
    int pick;
    dbl  = '0;
    base = 0;
    pick = -1;
    for (int i = 0; i < ARB_MAX_WAYS; i++) begin
      if (i < n) begin
        dbl[i]     = req[i];
        dbl[i + n] = req[i];
        if (ptr[i]) base = i + 1;
      end
    end
    if (base >= n) base = 0;
    for (int k = 0; k < ARB_MAX_WAYS; k++) begin
      if ((k < n) && (pick < 0) && dbl[base + k]) begin
        pick = (base + k >= n) ? (base + k - n) : (base + k);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/base_encode.sv
// One-hot to binary index encoder; index 0 is the leftmost input bit.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input. All-zero input encodes to 0.
module base_encode #(
  parameter int enc_width = 2,
  parameter int ways      = 4
) (
  input  logic [0:ways-1]      i_d,
  output logic [0:enc_width-1] o_d
);

  // OR together the indices of set bits; a one-hot input yields its index.
  always_comb begin
    o_d = '0;
    for (int i = 0; i < ways; i++) begin
      if (i_d[i]) o_d = o_d | enc_width'(i);
    end
  end

endmodule

// File: rtl/base_rr_pick.sv
// One-hot round-robin pick: first request strictly after ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is all-zero when nothing is requested.
module base_rr_pick
  import base_arb_pkg::*;
#(
  parameter int ways = 4
) (
  input  logic [0:ways-1] req,
  input  logic [0:ways-1] ptr,
  output logic [0:ways-1] gnt
);

  logic [ARB_MAX_WAYS-1:0] req_w;
  logic [ARB_MAX_WAYS-1:0] ptr_w;
  int                      pick_idx;

  // Widen to the helper's fixed width, search, then rebuild a one-hot grant.
  always_comb begin
    req_w = '0;
    ptr_w = '0;
    for (int i = 0; i < ways; i++) begin
      req_w[i] = req[i];
      ptr_w[i] = ptr[i];
    end
    pick_idx = rr_pick(req_w, ptr_w, ways);
    gnt = '0;
    for (int i = 0; i < ways; i++) begin
      gnt[i] = (pick_idx == i);
    end
  end

endmodule

// File: rtl/base_rr_arb.sv
// Round-robin arbiter sharing one valid/ready channel, locking per packet.
// Latency: zero-cycle request-to-grant in IDLE; grant held until last beat.
// Backpressure: a stalled grant locks the owner until its last beat moves.
module base_rr_arb
  import base_arb_pkg::*;
#(
  parameter int ways      = 4,
  parameter int enc_width = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:ways-1]      i_v,
  input  logic [0:ways-1]      i_last,
  output logic [0:ways-1]      i_r,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:ways-1]      o_sel,
  output logic [0:enc_width-1] o_enc,
  output logic                 o_lock
);

  arb_state_e      state_q, state_d;
  logic [0:ways-1] owner_q, owner_d;
  logic [0:ways-1] ptr_q,   ptr_d;

  logic [0:ways-1] pick;
  logic [0:ways-1] sel;
  logic            vld;
  logic            xfer;
  logic            last;

  // Last-served pointer starts on the top requester so requester 0 wins first.
  localparam logic [0:ways-1] PTR_RST = {{(ways-1){1'b0}}, 1'b1};

  base_rr_pick #(
    .ways (ways)
  ) u_pick (
    .req (i_v),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Select source, next-state and pointer update; fairness advances per packet.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q == ARB_LOCK) begin
      sel = owner_q;
      vld = |(i_v & owner_q);
    end else begin
      sel = pick;
      vld = |i_v;
    end
    xfer = vld & o_r;
    last = |(sel & i_last);
    if (state_q == ARB_IDLE) begin
      if (vld && !o_r) begin
        state_d = ARB_LOCK;
        owner_d = pick;
      end else if (xfer && !last) begin
        state_d = ARB_LOCK;
        owner_d = pick;
      end else if (xfer && last) begin
        ptr_d = pick;
      end
    end else begin
      if (xfer && last) begin
        state_d = ARB_IDLE;
        ptr_d   = owner_q;
        owner_d = '0;
      end
    end
  end

  // Outputs are forced quiet while reset is held, whatever the requests do.
  always_comb begin
    o_v    = reset & vld;
    o_sel  = sel & {ways{reset}};
    i_r    = sel & {ways{o_r & reset}};
    o_lock = reset & (state_q == ARB_LOCK);
  end

  base_encode #(
    .enc_width (enc_width),
    .ways      (ways)
  ) u_enc (
    .i_d (o_sel),
    .o_d (o_enc)
  );

  // Arbiter state; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_base_rr_arb.sv
// Self-checking bench for base_rr_arb: directed vector table plus random traffic.
// Latency: outputs sampled 2 ns after inputs change, mid-cycle.
// Backpressure: o_r is driven by the bench, both directed and random.
module tb_base_rr_arb;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [0:W-1] i_v;
  logic [0:W-1] i_last;
  logic [0:W-1] i_r;
  logic         o_v;
  logic         o_r;
  logic [0:W-1] o_sel;
  logic [0:1]   o_enc;
  logic         o_lock;

  int n_checks;
  int n_errors;

  // Reference model: owner index when locked, index of last-served requester.
  bit m_lock;
  int m_owner;
  int m_last;

  typedef struct {
    logic [0:W-1] v;
    logic [0:W-1] last;
    logic         r;
    logic         ov;
    logic [0:W-1] ir;
    logic [0:W-1] sel;
    int           enc;
    logic         lock;
    string        name;
  } vec_t;

  vec_t tbl[$];

  base_rr_arb #(
    .ways      (W),
    .enc_width (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_v    (i_v),
    .i_last (i_last),
    .i_r    (i_r),
    .o_v    (o_v),
    .o_r    (o_r),
    .o_sel  (o_sel),
    .o_enc  (o_enc),
    .o_lock (o_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lock  = 1'b0;
    m_owner = -1;
    m_last  = W - 1;
  endtask

  function automatic vec_t row(input logic [0:W-1] v, input logic [0:W-1] last,
                               input logic r, input logic ov, input logic [0:W-1] ir,
                               input logic [0:W-1] sel, input int enc,
                               input logic lock, input string name);
    vec_t e;
    e.v = v; e.last = last; e.r = r; e.ov = ov; e.ir = ir;
    e.sel = sel; e.enc = enc; e.lock = lock; e.name = name;
    return e;
  endfunction

  // Apply one cycle of inputs, compare against the model (and optionally a
  // table row), advance the model as the clock edge would, then step.
  task automatic run_cycle(input logic [0:W-1] v, input logic [0:W-1] last,
                           input logic r, input bit use_tbl, input vec_t e);
    int           sel_idx;
    logic [0:W-1] exp_sel;
    logic [0:W-1] exp_ir;
    logic         exp_v;
    bit           xfer;
    bit           is_last;
    i_v    = v;
    i_last = last;
    o_r    = r;
    #2;
    if (m_lock) begin
      sel_idx = m_owner;
      exp_v   = v[m_owner];
    end else begin
      sel_idx = -1;
      for (int k = 1; k <= W; k++) begin
        int j;
        j = (m_last + k) % W;
        if (sel_idx < 0 && v[j]) sel_idx = j;
      end
      exp_v = (v != '0);
    end
    exp_sel = '0;
    if (sel_idx >= 0) exp_sel[sel_idx] = 1'b1;
    exp_ir = r ? exp_sel : '0;
    check("model_o_v",    int'(o_v),    int'(exp_v));
    check("model_i_r",    int'(i_r),    int'(exp_ir));
    check("model_o_sel",  int'(o_sel),  int'(exp_sel));
    check("model_o_enc",  int'(o_enc),  (sel_idx < 0) ? 0 : sel_idx);
    check("model_o_lock", int'(o_lock), int'(m_lock));
    if (use_tbl) begin
      check({e.name, "_o_v"},    int'(o_v),    int'(e.ov));
      check({e.name, "_i_r"},    int'(i_r),    int'(e.ir));
      check({e.name, "_o_sel"},  int'(o_sel),  int'(e.sel));
      check({e.name, "_o_enc"},  int'(o_enc),  e.enc);
      check({e.name, "_o_lock"}, int'(o_lock), int'(e.lock));
    end
    xfer    = exp_v && r;
    is_last = (sel_idx >= 0) && last[sel_idx];
    if (m_lock) begin
      if (xfer && is_last) begin
        m_lock  = 1'b0;
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (exp_v && !r) begin
      m_lock  = 1'b1;
      m_owner = sel_idx;
    end else if (xfer && !is_last) begin
      m_lock  = 1'b1;
      m_owner = sel_idx;
    end else if (xfer) begin
      m_last = sel_idx;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t dummy;
    n_checks = 0;
    n_errors = 0;
    dummy = row('0, '0, 1'b0, 1'b0, '0, '0, 0, 1'b0, "none");

    // Round robin over all requesters, single-beat packets.
    tbl.push_back(row(4'b1111, 4'b1111, 1, 1, 4'b1000, 4'b1000, 0, 0, "rr0"));
    tbl.push_back(row(4'b1111, 4'b1111, 1, 1, 4'b0100, 4'b0100, 1, 0, "rr1"));
    tbl.push_back(row(4'b1111, 4'b1111, 1, 1, 4'b0010, 4'b0010, 2, 0, "rr2"));
    tbl.push_back(row(4'b1111, 4'b1111, 1, 1, 4'b0001, 4'b0001, 3, 0, "rr3"));
    tbl.push_back(row(4'b1111, 4'b1111, 1, 1, 4'b1000, 4'b1000, 0, 0, "rr4"));
    // Requester 1 three-beat packet while requester 2 waits.
    tbl.push_back(row(4'b0110, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1, 0, "pkt_b1"));
    tbl.push_back(row(4'b0110, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1, 1, "pkt_b2"));
    tbl.push_back(row(4'b0110, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 1, "pkt_b3"));
    tbl.push_back(row(4'b0010, 4'b0010, 1, 1, 4'b0010, 4'b0010, 2, 0, "pkt_next"));
    // Backpressure on requester 2 locks the grant against requester 0.
    tbl.push_back(row(4'b0010, 4'b0000, 0, 1, 4'b0000, 4'b0010, 2, 0, "bp0"));
    tbl.push_back(row(4'b1010, 4'b0000, 0, 1, 4'b0000, 4'b0010, 2, 1, "bp1"));
    tbl.push_back(row(4'b1010, 4'b0010, 0, 1, 4'b0000, 4'b0010, 2, 1, "bp2"));
    tbl.push_back(row(4'b1010, 4'b0010, 1, 1, 4'b0010, 4'b0010, 2, 1, "bp3"));
    // Owner 3 drops valid mid-packet; nobody else is granted meanwhile.
    tbl.push_back(row(4'b1101, 4'b0000, 1, 1, 4'b0001, 4'b0001, 3, 0, "drop0"));
    tbl.push_back(row(4'b1100, 4'b0000, 0, 0, 4'b0000, 4'b0001, 3, 1, "drop1"));
    tbl.push_back(row(4'b1100, 4'b0000, 0, 0, 4'b0000, 4'b0001, 3, 1, "drop2"));
    tbl.push_back(row(4'b1100, 4'b0000, 0, 0, 4'b0000, 4'b0001, 3, 1, "drop3"));
    tbl.push_back(row(4'b1101, 4'b0001, 1, 1, 4'b0001, 4'b0001, 3, 1, "drop4"));
    tbl.push_back(row(4'b1100, 4'b1100, 1, 1, 4'b1000, 4'b1000, 0, 0, "drop5"));

    // Reset held with every requester asking: outputs must stay quiet.
    reset  = 1'b0;
    i_v    = 4'b1111;
    i_last = 4'b0000;
    o_r    = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check("rst_o_v",    int'(o_v),    0);
    check("rst_i_r",    int'(i_r),    0);
    check("rst_o_sel",  int'(o_sel),  0);
    check("rst_o_enc",  int'(o_enc),  0);
    check("rst_o_lock", int'(o_lock), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (tbl[i]) run_cycle(tbl[i].v, tbl[i].last, tbl[i].r, 1'b1, tbl[i]);

    // Lock onto requester 2, then pulse reset mid-packet.
    run_cycle(4'b0010, 4'b0000, 1'b1, 1'b0, dummy);
    i_v = 4'b0010; i_last = 4'b0000; o_r = 1'b0;
    #1;
    check("pulse_lock_before", int'(o_lock), 1);
    check("pulse_sel_before",  int'(o_sel),  int'(4'b0010));
    reset = 1'b0;
    i_v   = 4'b1111;
    o_r   = 1'b1;
    #1;
    check("pulse_o_v",    int'(o_v),    0);
    check("pulse_i_r",    int'(i_r),    0);
    check("pulse_o_sel",  int'(o_sel),  0);
    check("pulse_o_enc",  int'(o_enc),  0);
    check("pulse_o_lock", int'(o_lock), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    run_cycle(4'b1111, 4'b0000, 1'b0, 1'b1,
              row(4'b1111, 4'b0000, 0, 1, 4'b0000, 4'b1000, 0, 0, "post_pulse"));
    run_cycle(4'b1111, 4'b1000, 1'b1, 1'b0, dummy);

    // Random traffic against the model, with an occasional reset pulse.
    for (int n = 0; n < 600; n++) begin
      logic [0:W-1] rv;
      logic [0:W-1] rl;
      logic         rr;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        check("rand_rst_o_v", int'(o_v), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
      end
      rv = 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      run_cycle(rv, rl, rr, 1'b0, dummy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
